// File: rtl/keyscan.sv
// 4x4 active-low key matrix scanner: strobes rows, samples columns once per row,
// debounces whole-frame results and reports each new press with a one-cycle strobe.
//   state | meaning
//   IDLE  | no key accepted; a debounced key press is reported on key_valid
//   HELD  | key accepted and held; waits for a debounced release
module keyscan #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int              DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB      = 4'(DEBOUNCE);

    typedef enum logic {IDLE, HELD} state_t;

    logic [3:0]       col_s1_q, col_s2_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       row_q;
    logic [3:0]       row_drv_q;
    logic             found_q;
    logic [3:0]       cand_q;
    logic             prev_found_q;
    logic [3:0]       prev_code_q;
    logic [3:0]       n_q, n_d;
    state_t           state_q;
    logic [3:0]       code_q;
    logic             valid_q, down_q;

    logic       sample, frame_end, col_hit, same, accept;
    logic [1:0] col_idx;
    logic       res_found;
    logic [3:0] res_code;

    always_comb begin
        sample    = (div_q == DIV_LAST);
        frame_end = sample && (row_q == 2'd3);
        col_hit   = (col_s2_q != 4'hF);
        if (!col_s2_q[0])      col_idx = 2'd0;
        else if (!col_s2_q[1]) col_idx = 2'd1;
        else if (!col_s2_q[2]) col_idx = 2'd2;
        else                   col_idx = 2'd3;
        // "none" is normalised to code 0 so the frame compare is a plain equality
        res_found = found_q | col_hit;
        if (found_q)      res_code = cand_q;
        else if (col_hit) res_code = {row_q, col_idx};
        else              res_code = 4'd0;
        same = (res_found == prev_found_q) && (res_code == prev_code_q);
        if (!same)              n_d = 4'd1;
        else if (n_q == 4'hF)   n_d = 4'hF;
        else                    n_d = n_q + 4'd1;
        // a saturated streak must not re-accept every frame
        accept = frame_end && (n_d == DEB) && !(same && (n_q == 4'hF));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1_q     <= 4'hF;
            col_s2_q     <= 4'hF;
            div_q        <= '0;
            row_q        <= 2'd0;
            row_drv_q    <= 4'b1110;
            found_q      <= 1'b0;
            cand_q       <= 4'd0;
            prev_found_q <= 1'b0;
            prev_code_q  <= 4'd0;
            n_q          <= DEB;
        end else begin
            col_s1_q <= key_col;
            col_s2_q <= col_s1_q;
            if (sample) begin
                div_q     <= '0;
                row_q     <= row_q + 2'd1;
                row_drv_q <= {row_drv_q[2:0], row_drv_q[3]};
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
            if (frame_end) begin
                found_q      <= 1'b0;
                cand_q       <= 4'd0;
                prev_found_q <= res_found;
                prev_code_q  <= res_code;
                n_q          <= n_d;
            end else if (sample && !found_q && col_hit) begin
                found_q <= 1'b1;
                cand_q  <= {row_q, col_idx};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    IDLE: if (res_found) begin
                        code_q  <= res_code;
                        valid_q <= 1'b1;
                        down_q  <= 1'b1;
                        state_q <= HELD;
                    end
                    HELD: if (!res_found) begin
                        down_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign key_row   = row_drv_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_down  = down_q;

endmodule

// File: tb/tb_keyscan.sv
// Bench for keyscan: two instances (DEBOUNCE 3 and 1) on a modelled key matrix,
// checked against a frame-level reference model of debounce and press reporting.
module tb_keyscan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mask0 = '0, mask1 = '0;
    logic [3:0]  col0, col1, row0, row1, code0, code1;
    logic        valid0, valid1, down0, down1;

    function automatic logic [3:0] matrix(input logic [15:0] m, input logic [3:0] row);
        logic [3:0] c;
        c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                if (!row[r] && m[r*4+cc]) c[cc] = 1'b0;
        return c;
    endfunction

    assign col0 = matrix(mask0, row0);
    assign col1 = matrix(mask1, row1);

    keyscan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk(clk), .rst(rst), .key_col(col0), .key_row(row0),
        .key_code(code0), .key_valid(valid0), .key_down(down0));

    keyscan #(.SCAN_DIV(4), .DEBOUNCE(1)) dut1 (
        .clk(clk), .rst(rst), .key_col(col1), .key_row(row1),
        .key_code(code1), .key_valid(valid1), .key_down(down1));

    int n_cmp = 0;
    int n_mis = 0;

    // reference model: recent frame results per instance, newest at index 0
    int hist [2][16];
    bit held [2];
    int mcode [2];
    int pc [2];
    int debv [2] = '{3, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 16; k++) hist[d][k] = (k < debv[d]) ? -1 : -2;
            held[d]  = 1'b0;
            mcode[d] = 0;
        end
    endtask

    task automatic model_frame(input int d, input int res, output bit pulse);
        bit acc;
        for (int k = 15; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = res;
        acc = 1'b1;
        for (int k = 0; k < debv[d]; k++) if (hist[d][k] != res) acc = 1'b0;
        if (hist[d][debv[d]] == res) acc = 1'b0;
        pulse = 1'b0;
        if (acc) begin
            if (!held[d] && res >= 0) begin
                pulse = 1'b1; held[d] = 1'b1; mcode[d] = res;
            end else if (held[d] && res < 0) begin
                held[d] = 1'b0;
            end
        end
    endtask

    task automatic run_frame(input logic [15:0] m0, input logic [15:0] m1);
        logic [3:0] exp_row;
        bit p0, p1;
        mask0 = m0;
        mask1 = m1;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            exp_row = ~(4'b0001 << ((i % 16) / 4));
            check("row0", row0, exp_row);
            check("row1", row1, exp_row);
            if (i < 16) begin
                check("valid0_mid", valid0, 0);
                check("valid1_mid", valid1, 0);
            end else begin
                model_frame(0, lowest(m0), p0);
                model_frame(1, lowest(m1), p1);
                if (p0) pc[0]++;
                if (p1) pc[1]++;
                check("valid0", valid0, p0);
                check("valid1", valid1, p1);
                check("down0", down0, held[0]);
                check("down1", down1, held[1]);
                check("code0", code0, mcode[0]);
                check("code1", code1, mcode[1]);
            end
        end
    endtask

    task automatic run_frames(input logic [15:0] m0, input logic [15:0] m1, input int n);
        for (int k = 0; k < n; k++) run_frame(m0, m1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row0"}, row0, 4'b1110);
        check({tag, "_code0"}, code0, 0);
        check({tag, "_valid0"}, valid0, 0);
        check({tag, "_down0"}, down0, 0);
        check({tag, "_row1"}, row1, 4'b1110);
        check({tag, "_down1"}, down1, 0);
    endtask

    initial begin
        int base;
        logic [15:0] m, mb;
        int sel, len;

        pc[0] = 0; pc[1] = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;
        model_reset();

        // idle
        run_frames(16'h0, 16'h0, 10);
        check("idle_pulses", pc[0], 0);

        // single key (2,1)
        run_frames(16'h0200, 16'h0200, 2);
        check("k9_no_early", pc[0], 0);
        run_frame(16'h0200, 16'h0200);
        check("k9_pulse", pc[0], 1);
        check("k9_code", code0, 9);
        run_frames(16'h0200, 16'h0200, 2);
        run_frames(16'h0, 16'h0, 2);
        check("k9_still_down", down0, 1);
        run_frame(16'h0, 16'h0);
        check("k9_released", down0, 0);
        check("k9_one_pulse", pc[0], 1);

        // bounce on (0,3)
        base = pc[0];
        for (int k = 0; k < 5; k++)
            run_frame((k % 2 == 0) ? 16'h0008 : 16'h0, (k % 2 == 0) ? 16'h0008 : 16'h0);
        check("bounce_no_pulse", pc[0], base);
        run_frame(16'h0008, 16'h0008);
        check("bounce_wait", pc[0], base);
        run_frame(16'h0008, 16'h0008);
        check("bounce_pulse", pc[0], base + 1);
        check("bounce_code", code0, 3);
        run_frames(16'h0, 16'h0, 4);

        // multi-press, rollover, re-press
        base = pc[0];
        run_frames(16'h8010, 16'h8010, 4);
        check("multi_code", code0, 4);
        check("multi_pulse", pc[0], base + 1);
        run_frames(16'h8000, 16'h8000, 4);
        check("roll_no_pulse", pc[0], base + 1);
        check("roll_code", code0, 4);
        check("roll_down", down0, 1);
        run_frames(16'h0, 16'h0, 4);
        check("roll_release", down0, 0);
        run_frames(16'h8000, 16'h8000, 4);
        check("k15_pulse", pc[0], base + 2);
        check("k15_code", code0, 15);

        // reset mid-frame with key held
        repeat (6) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst = 1'b1;
        model_reset();
        base = pc[0];
        run_frames(16'h8000, 16'h8000, 2);
        check("postrst_wait", pc[0], base);
        run_frame(16'h8000, 16'h8000);
        check("postrst_pulse", pc[0], base + 1);
        check("postrst_code", code0, 15);
        run_frames(16'h0, 16'h0, 4);

        // DEBOUNCE=1: one-frame press of (0,0)
        base = pc[1];
        run_frame(16'h0, 16'h0001);
        check("d1_pulse", pc[1], base + 1);
        check("d1_code", code1, 0);
        check("d1_down", down1, 1);
        run_frame(16'h0, 16'h0);
        check("d1_release", down1, 0);
        check("d1_one_pulse", pc[1], base + 1);

        // randomized key activity
        for (int s = 0; s < 40; s++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: m = 16'h0;
                1: m = 16'h1 << $urandom_range(0, 15);
                2: m = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                default: m = 16'($urandom);
            endcase
            mb = ($urandom_range(0, 1) == 0) ? m : (16'h1 << $urandom_range(0, 15));
            len = $urandom_range(1, 5);
            run_frames(m, mb, len);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
